// File: rtl/tcore_param.sv
// Shared constants and types for the UART debug bridge: bus width, command/response
// codes and the bridge FSM state type.
package tcore_param;

   localparam int unsigned XLEN = 32;

   localparam logic [7:0] DBG_CMD_WR  = 8'hA5;
   localparam logic [7:0] DBG_CMD_RD  = 8'h5A;
   localparam logic [7:0] DBG_RSP_ACK = 8'h06;
   localparam logic [7:0] DBG_RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StWdata,
      StBus,
      StResp
   } dbg_state_e;

endpackage

// File: rtl/uart_dbg_bridge_if.sv
// Single-word peripheral bus between the debug bridge (master) and a responder (slave).
interface uart_dbg_bridge_if;
   import tcore_param::*;

   logic            stb_o;
   logic            we_o;
   logic [XLEN-1:0] adr_o;
   logic [3:0]      byte_sel_o;
   logic [XLEN-1:0] dat_o;
   logic [XLEN-1:0] dat_i;
   logic            ack_i;

   modport master (
      output stb_o, we_o, adr_o, byte_sel_o, dat_o,
      input  dat_i, ack_i
   );

   modport slave (
      input  stb_o, we_o, adr_o, byte_sel_o, dat_o,
      output dat_i, ack_i
   );

endinterface

// File: rtl/uart_dbg_phy.sv
// 8N1 UART bit engines: RX with start-bit re-check and mid-bit sampling, TX with
// back-to-back byte chaining (a new byte may be accepted during the last stop-bit cycle).
module uart_dbg_phy #(
   parameter logic [15:0] BaudDiv = 16'd868
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic       tx_o,
   output logic       rx_valid_o,
   output logic [7:0] rx_byte_o,
   output logic       rx_ferr_o,
   input  logic       tx_start_i,
   input  logic [7:0] tx_byte_i,
   output logic       tx_busy_o
);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

   localparam logic [15:0] HalfDiv = BaudDiv >> 1;
   localparam logic [15:0] LastCnt = BaudDiv - 16'd1;

   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;

   logic        tx_busy_q, tx_busy_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]  tx_bit_q, tx_bit_d;
   logic [9:0]  tx_shift_q, tx_shift_d;
   logic        tx_last;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_valid_o = 1'b0;
      rx_ferr_o  = 1'b0;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
         end
         RxStart: begin
            if (rx_cnt_q == HalfDiv) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_sync_q ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == LastCnt) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cnt_q == LastCnt) begin
               rx_cnt_d   = '0;
               rx_state_d = RxIdle;
               rx_valid_o = rx_sync_q;
               rx_ferr_o  = !rx_sync_q;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   assign rx_byte_o = rx_shift_q;

   assign tx_last   = tx_busy_q && (tx_cnt_q == LastCnt) && (tx_bit_q == 4'd9);
   assign tx_busy_o = tx_busy_q && !tx_last;
   assign tx_o      = tx_busy_q ? tx_shift_q[0] : 1'b1;

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      if (tx_start_i && !tx_busy_o) begin
         tx_busy_d  = 1'b1;
         tx_cnt_d   = '0;
         tx_bit_d   = '0;
         tx_shift_d = {1'b1, tx_byte_i, 1'b0};
      end else if (tx_busy_q) begin
         if (tx_cnt_q == LastCnt) begin
            tx_cnt_d   = '0;
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
         end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '1;
      end else begin
         rx_meta_q  <= rx_i;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
      end
   end

endmodule

// File: rtl/uart_dbg_bridge.sv
// UART debug bridge: decodes framed read/write commands and replays them on the peripheral
// bus. Optional bus-wait timeout enabled by defining UART_DBG_TIMEOUT_EN.
module uart_dbg_bridge
   import tcore_param::*;
#(
   parameter logic [15:0] BAUD_DIV    = 16'd868,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              uart_rx_i,
   output logic              uart_tx_o,
   output logic              busy_o,
   uart_dbg_bridge_if.master bus
);

   logic       rx_valid, rx_ferr, tx_start, tx_busy;
   logic [7:0] rx_byte, tx_byte;

   dbg_state_e      state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] adr_q, adr_d, dat_q, dat_d;
   logic [31:0]     rsp_q, rsp_d;
   logic [2:0]      rsp_cnt_q, rsp_cnt_d;
   logic            tmo_hit;

   uart_dbg_phy #(.BaudDiv(BAUD_DIV)) u_phy (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .rx_i       (uart_rx_i),
      .tx_o       (uart_tx_o),
      .rx_valid_o (rx_valid),
      .rx_byte_o  (rx_byte),
      .rx_ferr_o  (rx_ferr),
      .tx_start_i (tx_start),
      .tx_byte_i  (tx_byte),
      .tx_busy_o  (tx_busy)
   );

`ifdef UART_DBG_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   assign tmo_hit = (tmo_q == TIMEOUT_CYC - 1);
   always_comb tmo_d = (state_q == StBus) ? tmo_q + 32'd1 : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) tmo_q <= '0;
      else       tmo_q <= tmo_d;
   end
`else
   logic unused_tmo_cfg;
   assign tmo_hit        = 1'b0;
   assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rsp_d     = rsp_q;
      rsp_cnt_d = rsp_cnt_q;
      tx_start  = 1'b0;
      tx_byte   = rsp_q[7:0];
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (rx_valid) begin
               if (rx_byte == DBG_CMD_WR || rx_byte == DBG_CMD_RD) begin
                  we_d    = (rx_byte == DBG_CMD_WR);
                  state_d = StAddr;
               end else begin
                  rsp_d     = {24'h0, DBG_RSP_NAK};
                  rsp_cnt_d = 3'd1;
                  state_d   = StResp;
               end
            end
         end
         StAddr, StWdata: begin
            if (rx_valid) begin
               if (state_q == StAddr) adr_d = {rx_byte, adr_q[XLEN-1:8]};
               else                   dat_d = {rx_byte, dat_q[XLEN-1:8]};
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = (state_q == StAddr && we_q) ? StWdata : StBus;
            end
         end
         StBus: begin
            // First response byte goes straight to TX so the start bit follows ack_i.
            if (bus.ack_i) begin
               tx_start  = 1'b1;
               tx_byte   = we_q ? DBG_RSP_ACK : bus.dat_i[7:0];
               rsp_d     = {8'h0, bus.dat_i[31:8]};
               rsp_cnt_d = we_q ? 3'd0 : 3'd3;
               state_d   = StResp;
            end else if (tmo_hit) begin
               rsp_d     = {24'h0, DBG_RSP_NAK};
               rsp_cnt_d = 3'd1;
               state_d   = StResp;
            end
         end
         StResp: begin
            if (!tx_busy) begin
               if (rsp_cnt_q != 3'd0) begin
                  tx_start  = 1'b1;
                  rsp_d     = {8'h0, rsp_q[31:8]};
                  rsp_cnt_d = rsp_cnt_q - 3'd1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (rx_ferr && (state_q == StIdle || state_q == StAddr || state_q == StWdata)) begin
         rsp_d     = {24'h0, DBG_RSP_NAK};
         rsp_cnt_d = 3'd1;
         state_d   = StResp;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         dat_q     <= '0;
         rsp_q     <= '0;
         rsp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rsp_q     <= rsp_d;
         rsp_cnt_q <= rsp_cnt_d;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign bus.stb_o      = (state_q == StBus);
   assign bus.we_o       = we_q;
   assign bus.adr_o      = adr_q;
   assign bus.dat_o      = dat_q;
   assign bus.byte_sel_o = bus.stb_o ? 4'hF : 4'h0;

endmodule

// File: tb/tb_uart_dbg_bridge.sv
// Scoreboard bench for uart_dbg_bridge: serial stimulus, bus responder, TX decoder.
module tb_uart_dbg_bridge;
   import tcore_param::*;

   localparam logic [15:0] BaudDiv = 16'd8;
   localparam int          Bd      = 8;
   localparam int unsigned TmoCyc  = 16;

   logic clk = 1'b0;
   logic rst, rx, tx, busy;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] exp_q[$];
   int   stb_rises = 0;
   logic stb_prev = 1'b0;
   logic [7:0] mon_b;

   uart_dbg_bridge_if bus_if ();

   uart_dbg_bridge #(.BAUD_DIV(BaudDiv), .TIMEOUT_CYC(TmoCyc)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .uart_rx_i (rx),
      .uart_tx_o (tx),
      .busy_o    (busy),
      .bus       (bus_if.master)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // TX decoder: pops the scoreboard at each received stop bit.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            repeat (Bd / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (Bd) @(negedge clk);
               mon_b[i] = tx;
            end
            repeat (Bd) @(negedge clk);
            check_eq("tx_stop_bit", {31'd0, tx}, 32'd1);
            check_eq("tx_byte_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check_eq("tx_byte", {24'd0, mon_b}, {24'd0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bus_if.stb_o && !stb_prev) stb_rises++;
         stb_prev = bus_if.stb_o;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (Bd) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (Bd) @(negedge clk);
      end
      rx = stop;
      repeat (Bd) @(negedge clk);
      rx = 1'b1;
      repeat (Bd) @(negedge clk);
   endtask

   task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
      send_byte(cmd, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(adr[8*i +: 8], 1'b1);
      if (cmd == DBG_CMD_WR) for (int i = 0; i < 4; i++) send_byte(dat[8*i +: 8], 1'b1);
   endtask

   task automatic wait_stb(input string tag);
      int i = 0;
      while (!bus_if.stb_o && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check_eq({tag, "_stb_seen"}, {31'd0, bus_if.stb_o}, 32'd1);
   endtask

   task automatic bus_txn(input string tag, input int ack_dly, input logic [31:0] rdata,
                          input logic exp_we, input logic [31:0] exp_adr,
                          input logic [31:0] exp_dat);
      wait_stb(tag);
      if (!bus_if.stb_o) return;
      check_eq({tag, "_we"}, {31'd0, bus_if.we_o}, {31'd0, exp_we});
      check_eq({tag, "_adr"}, bus_if.adr_o, exp_adr);
      check_eq({tag, "_bsel"}, {28'd0, bus_if.byte_sel_o}, 32'hF);
      if (exp_we) check_eq({tag, "_dat"}, bus_if.dat_o, exp_dat);
      repeat (ack_dly) @(negedge clk);
      check_eq({tag, "_stb_held"}, {31'd0, bus_if.stb_o}, 32'd1);
      if (exp_we) exp_q.push_back(DBG_RSP_ACK);
      else for (int i = 0; i < 4; i++) exp_q.push_back(rdata[8*i +: 8]);
      bus_if.dat_i = rdata;
      bus_if.ack_i = 1'b1;
      @(negedge clk);
      bus_if.ack_i = 1'b0;
      bus_if.dat_i = '0;
      check_eq({tag, "_stb_fall"}, {31'd0, bus_if.stb_o}, 32'd0);
      check_eq({tag, "_tx_start"}, {31'd0, tx}, 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while ((exp_q.size() != 0 || busy) && i < 5000) begin
         @(negedge clk);
         i++;
      end
      check_eq({tag, "_rsp_drained"}, exp_q.size(), 32'd0);
      check_eq({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      repeat (2 * Bd) @(negedge clk);
   endtask

   initial begin
      int r0, hi;
      rst = 1'b1;
      rx = 1'b1;
      bus_if.ack_i = 1'b0;
      bus_if.dat_i = '0;
      repeat (4) @(negedge clk);
      check_eq("rst_tx", {31'd0, tx}, 32'd1);
      check_eq("rst_stb", {31'd0, bus_if.stb_o}, 32'd0);
      check_eq("rst_we", {31'd0, bus_if.we_o}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_adr", bus_if.adr_o, 32'd0);
      check_eq("rst_dat", bus_if.dat_o, 32'd0);
      check_eq("rst_bsel", {28'd0, bus_if.byte_sel_o}, 32'd0);
      rst = 1'b0;
      repeat (2 * Bd) @(negedge clk);

      send_cmd(DBG_CMD_WR, 32'h0000_1000, 32'hDEAD_BEEF);
      bus_txn("wr", 3, 32'd0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
      wait_done("wr");

      send_cmd(DBG_CMD_RD, 32'h2000_0004, 32'd0);
      bus_txn("rd", 1, 32'h1234_5678, 1'b0, 32'h2000_0004, 32'd0);
      wait_done("rd");

      r0 = stb_rises;
      send_byte(8'h33, 1'b1);
      exp_q.push_back(DBG_RSP_NAK);
      wait_done("badcmd");
      check_eq("badcmd_no_stb", stb_rises, r0);

      send_byte(DBG_CMD_RD, 1'b1);
      send_byte(8'h01, 1'b0);
      exp_q.push_back(DBG_RSP_NAK);
      wait_done("ferr");
      send_cmd(DBG_CMD_RD, 32'h0000_0008, 32'd0);
      bus_txn("ferr_rd", 0, 32'hCAFE_F00D, 1'b0, 32'h0000_0008, 32'd0);
      wait_done("ferr_rd");

      send_cmd(DBG_CMD_RD, 32'h0000_0100, 32'd0);
      wait_stb("tmo");
      hi = 0;
`ifdef UART_DBG_TIMEOUT_EN
      for (int i = 0; i < 100 && bus_if.stb_o; i++) begin
         hi++;
         @(negedge clk);
      end
      check_eq("tmo_stb_cycles", hi, TmoCyc);
      exp_q.push_back(DBG_RSP_NAK);
      wait_done("tmo");
      send_cmd(DBG_CMD_RD, 32'h0000_0200, 32'd0);
      wait_stb("rstmid");
      @(negedge clk);
`else
      for (int i = 0; i < 1000; i++) begin
         if (bus_if.stb_o) hi++;
         @(negedge clk);
      end
      check_eq("notmo_stb_cycles", hi, 32'd1000);
`endif
      rst = 1'b1;
      @(negedge clk);
      check_eq("rstmid_stb", {31'd0, bus_if.stb_o}, 32'd0);
      check_eq("rstmid_tx", {31'd0, tx}, 32'd1);
      check_eq("rstmid_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (2 * Bd) @(negedge clk);

      send_cmd(DBG_CMD_WR, 32'h0000_0040, 32'h0BAD_F00D);
      bus_txn("wr2", 2, 32'd0, 1'b1, 32'h0000_0040, 32'h0BAD_F00D);
      wait_done("wr2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_dbg_bridge.md
# uart_dbg_bridge

Serial debug bridge: receives framed command bytes on a UART line and replays them as single-word read/write transactions on the core's memory-mapped peripheral bus. It is the initiator end of the `stb`/`we`/`adr`/`byte_sel`/`dat` interface that peripherals respond to. Host tools use it for memory load and peek/poke without CPU involvement. Read data and status are returned on the UART TX line.

## Interface
- `BAUD_DIV`, default 16'd868: clock cycles per serial bit, 8N1 framing; legal range 4..65535.
- `TIMEOUT_CYC`, default 256: bus-wait limit in cycles; used only when `UART_DBG_TIMEOUT_EN` is defined.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `uart_rx_i` in 1: serial input, idle high.
- `uart_tx_o` out 1: serial output, idle high.
- `stb_o` out 1: bus request.
- `we_o` out 1: 1 = write, 0 = read.
- `adr_o` out XLEN: byte address, driven exactly as received.
- `byte_sel_o` out 4: 4'hF while `stb_o` = 1, otherwise 4'h0.
- `dat_o` out XLEN: write data.
- `dat_i` in XLEN: read data, sampled on the cycle `ack_i` = 1.
- `ack_i` in 1: responder completion; one cycle per transaction.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- Command frame, all multi-byte fields little-endian:
  - Write: `0xA5`, 4 address bytes, 4 data bytes.
  - Read: `0x5A`, 4 address bytes.
- Responses:
  - Write completed: `0x06`.
  - Read completed: 4 data bytes, LSB first.
  - Error: `0x15` (NAK).
- FSM states: IDLE, ADDR (byte count 0..3), WDATA (0..3), BUS, RESP.
  - IDLE: `0xA5` goes to ADDR with `we` = 1; `0x5A` goes to ADDR with `we` = 0; any other byte queues NAK and goes to RESP.
  - ADDR: after the 4th byte, a write goes to WDATA and a read goes to BUS.
  - WDATA: after the 4th byte, goes to BUS.
  - BUS: holds `stb_o`, `we_o`, `adr_o`, `dat_o` stable until `ack_i`, then loads the response and goes to RESP.
  - RESP: transmits the queued bytes, then returns to IDLE.
- Bytes received in BUS or RESP are dropped. The host must wait for the response.
- RX: a falling edge starts a frame.
  - Start bit is re-checked at BAUD_DIV/2. If it reads high, the frame is a glitch and is ignored.
  - Each data bit is sampled at its mid-bit point.
  - A stop bit of 0 is a framing error: the byte is discarded, the FSM returns to IDLE, and a NAK is queued.
- TX: one start bit, 8 data bits LSB first, one stop bit. The next queued byte starts immediately after the previous stop bit.

## Timing
- Reset values: `uart_tx_o` = 1; `stb_o`, `we_o`, `busy_o` = 0; `adr_o`, `dat_o` = 0; `byte_sel_o` = 4'h0. Byte counters are cleared and the FSM is in IDLE.
- A reset mid-frame aborts both RX and TX. `uart_tx_o` returns high on the next cycle.
- `stb_o` rises on the cycle after the RX stop-bit sample of the final frame byte.
- `stb_o` falls on the cycle after `ack_i` is seen. `ack_i` in the same cycle that `stb_o` rises is legal and completes the transaction.
- The TX start bit begins on the cycle after `ack_i`.
- `ack_i` while `stb_o` = 0 is ignored.
- Baud counter counts 0..BAUD_DIV-1 and wraps. The RX counter is re-phased on every start edge.

## Configuration
- `UART_DBG_TIMEOUT_EN` defined:
  - In BUS, a counter increments every cycle.
  - If it reaches TIMEOUT_CYC-1 without `ack_i`, `stb_o` drops on the next cycle and NAK `0x15` is sent instead of the normal response.
  - An `ack_i` arriving on the terminal cycle wins (normal completion).
- Undefined: BUS waits indefinitely. The counter logic is not synthesized.

## Structure
- Shared package `tcore_param` holds:
  - Command constants: `DBG_CMD_WR` = 8'hA5, `DBG_CMD_RD` = 8'h5A, `DBG_RSP_ACK` = 8'h06, `DBG_RSP_NAK` = 8'h15.
  - The FSM state enum type.
- One sub-module, `uart_dbg_phy`: the RX/TX bit engines (baud counters and shift registers).
  - Byte interface: `rx_valid`/`rx_byte`/`rx_ferr` and `tx_start`/`tx_byte`/`tx_busy`.
  - FSM, address/data registers and the response queue (up to 4 bytes) live in `uart_dbg_bridge`.

## Test plan
BAUD_DIV = 8 for all scenarios.
- Write: send A5 00 10 00 00 EF BE AD DE, ack_i 3 cycles after stb_o. Expect `adr_o` = 0x00001000, `dat_o` = 0xDEADBEEF, `we_o` = 1, `byte_sel_o` = F, then TX 0x06.
- Read: send 5A 04 00 00 20, ack_i with `dat_i` = 0x12345678. Expect `we_o` = 0, then TX 78 56 34 12.
- Bad command: send 0x33. Expect TX 0x15, no `stb_o`, `busy_o` low after the stop bit.
- Framing error: send a byte with stop bit 0 during ADDR. Expect NAK, then a following valid read completes normally.
- Timeout, macro defined with TIMEOUT_CYC = 16: read with no ack. Expect `stb_o` high exactly 16 cycles, then TX 0x15. Without the macro, `stb_o` stays high for 1000 cycles.
- Reset mid-transaction: assert `rst_i` while `stb_o` = 1. Next cycle: `stb_o` = 0 and `uart_tx_o` = 1; then a fresh write succeeds.
